// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the decode stage: opcodes, immediate formats
// and the {pc, insn} entry carried through the elastic buffer.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  // FMT_NONE: no immediate (R-type, FENCE); FMT_BAD: opcode not in RV32I.
  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } decode_entry_t;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: classifies the opcode into a format,
// builds the sign-extended immediate and flags malformed funct3 fields.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic [31:0] imm_o,
  output imm_fmt_e    fmt_o,
  output logic        illegal_o
);

  logic [2:0] funct3;
  assign funct3 = insn_i[14:12];

  // illegal_o covers bad fields of known opcodes; unknown opcodes surface as FMT_BAD.
  always_comb begin
    fmt_o     = FMT_BAD;
    illegal_o = (insn_i[1:0] != 2'b11);
    case (insn_i[6:0])
      OP_LOAD: begin
        fmt_o = FMT_I;
        if (funct3 == 3'd3 || funct3 >= 3'd6) illegal_o = 1'b1;
      end
      OP_IMM, OP_SYSTEM: fmt_o = FMT_I;
      OP_JALR: begin
        fmt_o = FMT_I;
        if (funct3 != 3'd0) illegal_o = 1'b1;
      end
      OP_STORE: begin
        fmt_o = FMT_S;
        if (funct3 > 3'd2) illegal_o = 1'b1;
      end
      OP_BRANCH: begin
        fmt_o = FMT_B;
        if (funct3 == 3'd2 || funct3 == 3'd3) illegal_o = 1'b1;
      end
      OP_LUI, OP_AUIPC: fmt_o = FMT_U;
      OP_JAL:           fmt_o = FMT_J;
      OP_REG, OP_FENCE: fmt_o = FMT_NONE;
      default:          fmt_o = FMT_BAD;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (fmt_o)
      FMT_I: imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
      FMT_S: imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      FMT_B: imm_o = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                      insn_i[11:8], 1'b0};
      FMT_U: imm_o = {insn_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                      insn_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: two-entry elastic buffer (main + skid) between fetch
// and execute, with field/immediate decode taken from the main register.
module decode
  import rv32i_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              insn_valid_i,
  output logic              insn_ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              flush_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [AWIDTH-1:0] dec_pc_o,
  output logic [DWIDTH-1:0] dec_insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [31:0]       imm_o,
  output logic              illegal_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]    state_q, state_d;
  decode_entry_t main_q, main_d;
  decode_entry_t skid_q, skid_d;
  decode_entry_t in_entry;
  logic          in_xfer, out_xfer;
  imm_fmt_e      imm_fmt;
  logic          fld_illegal;

  assign in_entry     = {pc_i, insn_i};
  assign insn_ready_o = (state_q != ST_TWO);
  assign dec_valid_o  = (state_q != ST_EMPTY);
  assign in_xfer      = insn_valid_i && insn_ready_o;
  assign out_xfer     = dec_valid_o && dec_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Redirect: drop everything but leave the data registers untouched.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_entry;
          end else if (in_xfer) begin
            skid_d  = in_entry;
            state_d = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '{pc: '0, insn: NOP_INSN};
      skid_q  <= '{pc: '0, insn: NOP_INSN};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign dec_pc_o   = main_q.pc;
  assign dec_insn_o = main_q.insn;
  assign opcode_o   = main_q.insn[6:0];
  assign rd_o       = main_q.insn[11:7];
  assign rs1_o      = main_q.insn[19:15];
  assign rs2_o      = main_q.insn[24:20];
  assign funct3_o   = main_q.insn[14:12];
  assign funct7_o   = main_q.insn[31:25];

  imm_gen u_imm_gen (
    .insn_i    (main_q.insn),
    .imm_o     (imm_o),
    .fmt_o     (imm_fmt),
    .illegal_o (fld_illegal)
  );

  assign illegal_o = dec_valid_o && (fld_illegal || imm_fmt == FMT_BAD);

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: a vector table for field/immediate
// decode plus hand-written handshake, backpressure, flush and reset sequences.
module tb_decode;

  logic        clk;
  logic        rst;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] pc;
  logic [31:0] insn;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_insn;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  decode #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .insn_valid_i (insn_valid),
    .insn_ready_o (insn_ready),
    .pc_i         (pc),
    .insn_i       (insn),
    .flush_i      (flush),
    .dec_valid_o  (dec_valid),
    .dec_ready_i  (dec_ready),
    .dec_pc_o     (dec_pc),
    .dec_insn_o   (dec_insn),
    .opcode_o     (opcode),
    .rd_o         (rd),
    .rs1_o        (rs1),
    .rs2_o        (rs2),
    .funct3_o     (funct3),
    .funct7_o     (funct7),
    .imm_o        (imm),
    .illegal_o    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    insn_valid = 1'b1;
    pc         = p;
    insn       = i;
  endtask

  localparam logic [31:0] IA = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] IB = 32'h0020_0113;  // addi x2,x0,2
  localparam logic [31:0] IC = 32'h0030_0193;  // addi x3,x0,3
  localparam logic [31:0] ID = 32'h0040_0213;  // addi x4,x0,4
  localparam logic [31:0] PA = 32'h0000_1000;
  localparam logic [31:0] PB = 32'h0000_1004;
  localparam logic [31:0] PC = 32'h0000_1008;
  localparam logic [31:0] PD = 32'h0000_2000;

  initial begin
    rst        = 1'b0;
    insn_valid = 1'b0;
    pc         = '0;
    insn       = '0;
    flush      = 1'b0;
    dec_ready  = 1'b1;

    //                 insn           imm            ill   rd     rs1
    vecs[0]  = '{32'hFFF0_0093, 32'hFFFF_FFFF, 1'b0, 5'd1,  5'd0};   // addi x1,x0,-1
    vecs[1]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0, 5'd29, 5'd0};   // beq -4
    vecs[2]  = '{32'h0080_006F, 32'h0000_0008, 1'b0, 5'd0,  5'd0};   // jal +8
    vecs[3]  = '{32'h1234_5037, 32'h1234_5000, 1'b0, 5'd0,  5'd8};   // lui
    vecs[4]  = '{32'h0011_2623, 32'h0000_000C, 1'b0, 5'd12, 5'd2};   // sw x1,12(x2)
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 5'd0,  5'd0};   // all zero
    vecs[6]  = '{32'h0000_207F, 32'h0000_0000, 1'b1, 5'd0,  5'd0};   // opcode 7F
    vecs[7]  = '{32'h0000_2063, 32'h0000_0000, 1'b1, 5'd0,  5'd0};   // branch f3=2
    vecs[8]  = '{32'h0000_3003, 32'h0000_0000, 1'b1, 5'd0,  5'd0};   // load f3=3
    vecs[9]  = '{32'h0000_1067, 32'h0000_0000, 1'b1, 5'd0,  5'd0};   // jalr f3=1
    vecs[10] = '{32'h0000_3023, 32'h0000_0000, 1'b1, 5'd0,  5'd0};   // store f3=3
    vecs[11] = '{32'hFFFF_F097, 32'hFFFF_F000, 1'b0, 5'd1,  5'd31};  // auipc
    vecs[12] = '{32'h8000_2083, 32'hFFFF_F800, 1'b0, 5'd1,  5'd0};   // lw x1,-2048(x0)
    vecs[13] = '{32'h0020_81B3, 32'h0000_0000, 1'b0, 5'd3,  5'd1};   // add x3,x1,x2
    vecs[14] = '{32'h0FF0_000F, 32'h0000_0000, 1'b0, 5'd0,  5'd0};   // fence
    vecs[15] = '{32'h0000_0073, 32'h0000_0000, 1'b0, 5'd0,  5'd0};   // ecall
    vecs[16] = '{32'h0000_0011, 32'h0000_0000, 1'b1, 5'd0,  5'd0};   // insn[1:0]=01

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_insn_ready", insn_ready, 1);
    check("rst_imm", imm, 0);
    check("rst_illegal", illegal, 0);
    check("rst_opcode", opcode, 32'h13);
    check("rst_dec_insn", dec_insn, 32'h13);
    check("rst_dec_pc", dec_pc, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_dec_valid", dec_valid, 0);

    // Vector table: one instruction in, checked the cycle after acceptance
    for (int i = 0; i < 17; i++) begin
      push(32'h0100_0000 + 32'(i) * 4, vecs[i].insn);
      @(negedge clk);
      insn_valid = 1'b0;
      $display("vec %0d insn=%08h imm=%08h ill=%0b rd=%0d rs1=%0d",
               i, vecs[i].insn, imm, illegal, rd, rs1);
      check($sformatf("vec%0d_valid", i), dec_valid, 1);
      check($sformatf("vec%0d_pc", i), dec_pc, 32'h0100_0000 + 32'(i) * 4);
      check($sformatf("vec%0d_insn", i), dec_insn, vecs[i].insn);
      check($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
      check($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].rd);
      check($sformatf("vec%0d_rs1", i), rs1, vecs[i].rs1);
      check($sformatf("vec%0d_opcode", i), opcode, vecs[i].insn & 32'h7F);
      @(negedge clk);
      check($sformatf("vec%0d_drained", i), dec_valid, 0);
    end

    // Back-to-back stream of 8 with execute always ready
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        $display("stream %0d pc=%08h valid=%0b ready=%0b", k - 1, dec_pc, dec_valid, insn_ready);
        check($sformatf("stream%0d_valid", k - 1), dec_valid, 1);
        check($sformatf("stream%0d_pc", k - 1), dec_pc, 32'h0000_4000 + 32'(k - 1) * 4);
        check($sformatf("stream%0d_insn", k - 1), dec_insn, 32'h0000_0013 | (32'(k) << 20));
        check($sformatf("stream%0d_insn_ready", k - 1), insn_ready, 1);
      end
      if (k < 8) push(32'h0000_4000 + 32'(k) * 4, 32'h0000_0013 | (32'(k + 1) << 20));
      else insn_valid = 1'b0;
      @(negedge clk);
    end
    check("stream_end_valid", dec_valid, 0);

    // Backpressure: A held, B in skid, C stalled, then A, B, C in order
    dec_ready = 1'b0;
    push(PA, IA);
    @(negedge clk);
    check("bp_a_pc", dec_pc, PA);
    check("bp_a_ready", insn_ready, 1);
    push(PB, IB);
    @(negedge clk);
    check("bp_hold1_pc", dec_pc, PA);
    check("bp_hold1_ready", insn_ready, 0);
    push(PC, IC);
    @(negedge clk);
    check("bp_hold2_pc", dec_pc, PA);
    check("bp_hold2_insn", dec_insn, IA);
    check("bp_hold2_imm", imm, 1);
    check("bp_hold2_ready", insn_ready, 0);
    dec_ready = 1'b1;
    @(negedge clk);
    $display("bp release out pc=%08h", dec_pc);
    check("bp_b_pc", dec_pc, PB);
    check("bp_b_insn", dec_insn, IB);
    check("bp_b_ready", insn_ready, 1);
    @(negedge clk);
    insn_valid = 1'b0;
    $display("bp release out pc=%08h", dec_pc);
    check("bp_c_pc", dec_pc, PC);
    check("bp_c_insn", dec_insn, IC);
    @(negedge clk);
    check("bp_empty", dec_valid, 0);

    // Flush while in TWO with fetch still offering
    dec_ready = 1'b0;
    push(PA, IA);
    @(negedge clk);
    push(PB, IB);
    @(negedge clk);
    check("fl2_in_two", insn_ready, 0);
    push(PC, IC);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    insn_valid = 1'b0;
    $display("flush TWO valid=%0b ready=%0b", dec_valid, insn_ready);
    check("fl2_valid", dec_valid, 0);
    check("fl2_ready", insn_ready, 1);
    check("fl2_illegal", illegal, 0);
    @(negedge clk);
    check("fl2_still_empty", dec_valid, 0);
    dec_ready = 1'b1;
    push(PD, ID);
    @(negedge clk);
    insn_valid = 1'b0;
    check("fl2_next_pc", dec_pc, PD);
    check("fl2_next_insn", dec_insn, ID);
    @(negedge clk);
    check("fl2_drained", dec_valid, 0);

    // Flush in ONE: the concurrent input must be dropped
    dec_ready = 1'b0;
    push(PA, IA);
    @(negedge clk);
    push(PB, IB);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    insn_valid = 1'b0;
    $display("flush ONE valid=%0b ready=%0b", dec_valid, insn_ready);
    check("fl1_valid", dec_valid, 0);
    check("fl1_ready", insn_ready, 1);
    @(negedge clk);
    check("fl1_still_empty", dec_valid, 0);

    // Reset asserted mid-stream from TWO
    push(PA, IA);
    @(negedge clk);
    push(PB, IB);
    @(negedge clk);
    insn_valid = 1'b0;
    rst = 1'b0;
    #1;
    $display("mid reset valid=%0b ready=%0b insn=%08h", dec_valid, insn_ready, dec_insn);
    check("mrst_valid", dec_valid, 0);
    check("mrst_ready", insn_ready, 1);
    check("mrst_insn", dec_insn, 32'h13);
    check("mrst_pc", dec_pc, 0);
    @(negedge clk);
    rst = 1'b1;
    dec_ready = 1'b1;
    @(negedge clk);
    check("mrst_after", dec_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
